// File: rtl/axi_struct_pkg.sv
// ----------------------------------------------------------------------------
// axi_struct_pkg
// AXI4 manager-side request/response bundles, 32-bit address/data, 4-bit IDs.
//   axi_wr_req_t : AW + W payload, awvalid, wvalid, bready
//   axi_wr_rsp_t : awready, wready, B payload, bvalid
//   axi_rd_req_t : AR payload, arvalid, rready
//   axi_rd_rsp_t : arready, R payload, rvalid
// ----------------------------------------------------------------------------
package axi_struct_pkg;

    localparam int ID_W = 4;

    typedef struct packed {
        logic [ID_W-1:0] aw_id;
        logic [31:0]     aw_addr;
        logic [7:0]      aw_len;
        logic [2:0]      aw_size;
        logic [1:0]      aw_burst;
        logic            aw_valid;
        logic [31:0]     w_data;
        logic [3:0]      w_strb;
        logic            w_last;
        logic            w_valid;
        logic            b_ready;
    } axi_wr_req_t;

    typedef struct packed {
        logic            aw_ready;
        logic            w_ready;
        logic [ID_W-1:0] b_id;
        logic [1:0]      b_resp;
        logic            b_valid;
    } axi_wr_rsp_t;

    typedef struct packed {
        logic [ID_W-1:0] ar_id;
        logic [31:0]     ar_addr;
        logic [7:0]      ar_len;
        logic [2:0]      ar_size;
        logic [1:0]      ar_burst;
        logic            ar_valid;
        logic            r_ready;
    } axi_rd_req_t;

    typedef struct packed {
        logic            ar_ready;
        logic [ID_W-1:0] r_id;
        logic [31:0]     r_data;
        logic [1:0]      r_resp;
        logic            r_last;
        logic            r_valid;
    } axi_rd_rsp_t;

endpackage

// File: rtl/tlul_axi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// tlul_axi_bridge_pkg
// Bridge FSM state encoding, AXI burst/response constants and the byte-lane
// mask helper used by the A-channel check.
// ----------------------------------------------------------------------------
package tlul_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Byte lanes covered by an access of 2**size bytes at the given low
    // address bits. Misaligned offsets are rounded down to the access size;
    // an unsupported size covers no lanes at all.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addr_lo;
            2'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// ----------------------------------------------------------------------------
// tlul_pkg
// TL-UL channel structures and opcode encodings shared by the bridge and its
// environment. 32-bit address/data, 4 byte lanes, 8-bit source ID.
//   tl_h2d_t : A channel (host -> device) plus d_ready
//   tl_d2h_t : D channel (device -> host) plus a_ready
// ----------------------------------------------------------------------------
package tlul_pkg;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'h0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'h1;
    localparam logic [2:0] OP_GET         = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK      = 3'h0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_axi_a_chk.sv
// ----------------------------------------------------------------------------
// tlul_axi_a_chk
// Combinational legality check of a TL-UL A-channel request.
//   opcode_i   : A opcode
//   address_i  : low two address bits (the only ones that affect legality)
//   size_i     : log2 of the access size in bytes
//   mask_i     : byte-lane mask
//   err_o      : request must be answered with an error and never reach AXI
//   is_write_o : opcode is PutFullData or PutPartialData
// ----------------------------------------------------------------------------
module tlul_axi_a_chk
    import tlul_pkg::*;
    import tlul_axi_bridge_pkg::*;
#(
    parameter bit AddrAlignChk = 1'b1
) (
    input  logic [2:0] opcode_i,
    input  logic [1:0] address_i,
    input  logic [1:0] size_i,
    input  logic [3:0] mask_i,
    output logic       err_o,
    output logic       is_write_o
);

    logic [3:0] lanes;
    logic       op_ok;
    logic       is_full;
    logic       misaligned;

    // Evaluate every error condition on the request fields.
    always_comb begin
        lanes      = lane_mask(size_i, address_i);
        is_full    = (opcode_i == OP_PUT_FULL);
        is_write_o = is_full || (opcode_i == OP_PUT_PARTIAL);
        op_ok      = is_write_o || (opcode_i == OP_GET);
        case (size_i)
            2'd1:    misaligned = address_i[0];
            2'd2:    misaligned = (address_i != 2'b00);
            default: misaligned = 1'b0;
        endcase
        err_o = !op_ok
              || (size_i > 2'd2)
              || (AddrAlignChk && misaligned)
              || (is_full && (mask_i != lanes))
              || ((mask_i & ~lanes) != 4'b0000);
    end

endmodule

// File: rtl/tlul_axi_bridge.sv
// ----------------------------------------------------------------------------
// tlul_axi_bridge
// TL-UL device port to AXI4 manager. One transaction in flight: a TL-UL
// request is captured in IDLE, turned into a single-beat AXI write (AW/W/B)
// or read (AR/R), and answered on the D channel once the AXI response lands.
//   clk, rst     : clock, synchronous active-high reset
//   tl_h2d_i     : TL-UL A channel plus d_ready
//   tl_d2h_o     : TL-UL D channel plus a_ready
//   axi_wr_req_o : AW/W payload, awvalid, wvalid, bready
//   axi_wr_rsp_i : awready, wready, B payload, bvalid
//   axi_rd_req_o : AR payload, arvalid, rready
//   axi_rd_rsp_i : arready, R payload, rvalid
// All handshake outputs come straight from registers.
// ----------------------------------------------------------------------------
module tlul_axi_bridge
    import tlul_pkg::*;
    import axi_struct_pkg::*;
    import tlul_axi_bridge_pkg::*;
#(
    parameter int AxiId        = 0,
    parameter bit AddrAlignChk = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  tlul_pkg::tl_h2d_t           tl_h2d_i,
    output tlul_pkg::tl_d2h_t           tl_d2h_o,
    output axi_struct_pkg::axi_wr_req_t axi_wr_req_o,
    input  axi_struct_pkg::axi_wr_rsp_t axi_wr_rsp_i,
    output axi_struct_pkg::axi_rd_req_t axi_rd_req_o,
    input  axi_struct_pkg::axi_rd_rsp_t axi_rd_rsp_i
);

    localparam logic [ID_W-1:0] AXI_ID = AxiId[ID_W-1:0];

    state_e      state_q;
    logic        a_ready_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        b_ready_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        d_valid_q;
    logic        d_error_q;
    logic [2:0]  d_opcode_q;
    logic [31:0] d_data_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [7:0]  source_q;
    logic [3:0]  mask_q;

    logic        chk_err;
    logic        chk_is_write;
    logic        a_fire;
    logic        aw_pending;
    logic        w_pending;
    logic        unused_a_param;

    assign unused_a_param = ^tl_h2d_i.a_param;

    // The check looks at the request on the accepting edge so the result is
    // registered together with the captured fields; this keeps the first AXI
    // valid one cycle after acceptance.
    tlul_axi_a_chk #(
        .AddrAlignChk (AddrAlignChk)
    ) u_a_chk (
        .opcode_i   (tl_h2d_i.a_opcode),
        .address_i  (tl_h2d_i.a_address[1:0]),
        .size_i     (tl_h2d_i.a_size),
        .mask_i     (tl_h2d_i.a_mask),
        .err_o      (chk_err),
        .is_write_o (chk_is_write)
    );

    assign a_fire     = a_ready_q && tl_h2d_i.a_valid;
    // A channel is still outstanding if its valid has not met ready yet.
    assign aw_pending = aw_valid_q && !axi_wr_rsp_i.aw_ready;
    assign w_pending  = w_valid_q  && !axi_wr_rsp_i.w_ready;

    // Bridge FSM: sequences the TL accept, the AXI handshakes and the D reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            d_error_q  <= 1'b0;
            d_opcode_q <= 3'h0;
            d_data_q   <= 32'h0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            size_q     <= 2'h0;
            source_q   <= 8'h0;
            mask_q     <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        a_ready_q  <= 1'b0;
                        addr_q     <= tl_h2d_i.a_address;
                        data_q     <= tl_h2d_i.a_data;
                        size_q     <= tl_h2d_i.a_size;
                        source_q   <= tl_h2d_i.a_source;
                        mask_q     <= tl_h2d_i.a_mask;
                        d_opcode_q <= (tl_h2d_i.a_opcode == OP_GET) ? OP_ACCESS_ACK_DATA
                                                                    : OP_ACCESS_ACK;
                        d_data_q   <= 32'h0;
                        if (chk_err) begin
                            d_valid_q <= 1'b1;
                            d_error_q <= 1'b1;
                            state_q   <= ST_RSP;
                        end else if (chk_is_write) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= ST_WR_AW_W;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    // Each valid drops on its own handshake and never returns.
                    if (aw_valid_q && axi_wr_rsp_i.aw_ready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_valid_q && axi_wr_rsp_i.w_ready) begin
                        w_valid_q <= 1'b0;
                    end
                    if (!aw_pending && !w_pending) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi_wr_rsp_i.b_valid) begin
                        b_ready_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        d_error_q <= axi_wr_rsp_i.b_resp[1] || (axi_wr_rsp_i.b_id != AXI_ID);
                        d_data_q  <= 32'h0;
                        state_q   <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (axi_rd_rsp_i.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (axi_rd_rsp_i.r_valid) begin
                        r_ready_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        if (axi_rd_rsp_i.r_resp[1] || (axi_rd_rsp_i.r_id != AXI_ID)
                                || !axi_rd_rsp_i.r_last) begin
                            d_error_q <= 1'b1;
                            d_data_q  <= 32'h0;
                        end else begin
                            d_error_q <= 1'b0;
                            d_data_q  <= axi_rd_rsp_i.r_data;
                        end
                        state_q <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // D fields are only touched once the host has taken them.
                    if (tl_h2d_i.d_ready) begin
                        d_valid_q <= 1'b0;
                        d_error_q <= 1'b0;
                        d_data_q  <= 32'h0;
                        a_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    a_ready_q  <= 1'b0;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    d_valid_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the TL-UL D channel and a_ready from registered state.
    always_comb begin
        tl_d2h_o          = '0;
        tl_d2h_o.d_valid  = d_valid_q;
        tl_d2h_o.d_opcode = d_opcode_q;
        tl_d2h_o.d_param  = 3'h0;
        tl_d2h_o.d_size   = size_q;
        tl_d2h_o.d_source = source_q;
        tl_d2h_o.d_sink   = 1'b0;
        tl_d2h_o.d_data   = d_data_q;
        tl_d2h_o.d_user   = 4'h0;
        tl_d2h_o.d_error  = d_error_q;
        tl_d2h_o.a_ready  = a_ready_q;
    end

    // Drive the AXI write request bundle; payload is held in registers.
    always_comb begin
        axi_wr_req_o          = '0;
        axi_wr_req_o.aw_id    = AXI_ID;
        axi_wr_req_o.aw_addr  = addr_q;
        axi_wr_req_o.aw_len   = 8'h00;
        axi_wr_req_o.aw_size  = {1'b0, size_q};
        axi_wr_req_o.aw_burst = BURST_INCR;
        axi_wr_req_o.aw_valid = aw_valid_q;
        axi_wr_req_o.w_data   = data_q;
        axi_wr_req_o.w_strb   = mask_q;
        axi_wr_req_o.w_last   = 1'b1;
        axi_wr_req_o.w_valid  = w_valid_q;
        axi_wr_req_o.b_ready  = b_ready_q;
    end

    // Drive the AXI read request bundle.
    always_comb begin
        axi_rd_req_o          = '0;
        axi_rd_req_o.ar_id    = AXI_ID;
        axi_rd_req_o.ar_addr  = addr_q;
        axi_rd_req_o.ar_len   = 8'h00;
        axi_rd_req_o.ar_size  = {1'b0, size_q};
        axi_rd_req_o.ar_burst = BURST_INCR;
        axi_rd_req_o.ar_valid = ar_valid_q;
        axi_rd_req_o.r_ready  = r_ready_q;
    end

endmodule

// File: tb/tb_tlul_axi_bridge.sv
// ----------------------------------------------------------------------------
// tb_tlul_axi_bridge
// Directed bench for tlul_axi_bridge (AxiId=0, alignment check on). Inputs are
// driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_tlul_axi_bridge;
    import tlul_pkg::*;
    import axi_struct_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;
    axi_wr_req_t wr_req;
    axi_wr_rsp_t wr_rsp;
    axi_rd_req_t rd_req;
    axi_rd_rsp_t rd_rsp;

    int n_vec  = 0;
    int n_miss = 0;

    // Observations collected by the responder task
    bit          obs_got;
    int          obs_lat;
    bit          obs_aw;
    bit          obs_ar;
    logic [31:0] obs_addr;
    logic [3:0]  obs_strb;
    logic [2:0]  obs_op;
    logic        obs_err;
    logic [31:0] obs_data;
    logic [7:0]  obs_src;
    logic [1:0]  obs_size;

    always #5 clk = ~clk;

    tlul_axi_bridge #(.AxiId(0), .AddrAlignChk(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .tl_h2d_i     (tl_h2d),
        .tl_d2h_o     (tl_d2h),
        .axi_wr_req_o (wr_req),
        .axi_wr_rsp_i (wr_rsp),
        .axi_rd_req_o (rd_req),
        .axi_rd_rsp_i (rd_rsp)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present an A request and wait for acceptance; returns at the falling edge
    // after the accepting rising edge (cycle 1 of the transaction).
    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                           output bit ok);
        tl_h2d.a_opcode  = op;
        tl_h2d.a_address = addr;
        tl_h2d.a_size    = size;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_data    = data;
        tl_h2d.a_source  = src;
        tl_h2d.a_valid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (tl_d2h.a_ready) ok = 1'b1;
            @(negedge clk);
        end
        tl_h2d.a_valid = 1'b0;
    endtask

    // Zero-wait AXI subordinate; runs until d_valid is seen (optionally acking it).
    task automatic respond(input bit ack_d, input logic [3:0] id, input logic [1:0] resp,
                           input logic last, input logic [31:0] rdata);
        obs_got = 1'b0; obs_lat = 0; obs_aw = 1'b0; obs_ar = 1'b0;
        obs_addr = 32'h0; obs_strb = 4'h0;
        wr_rsp.aw_ready = 1'b1; wr_rsp.w_ready = 1'b1; rd_rsp.ar_ready = 1'b1;
        wr_rsp.b_id = id; wr_rsp.b_resp = resp;
        rd_rsp.r_id = id; rd_rsp.r_resp = resp; rd_rsp.r_last = last; rd_rsp.r_data = rdata;
        for (int i = 1; i <= 40 && !obs_got; i++) begin
            if (wr_req.aw_valid) begin obs_aw = 1'b1; obs_addr = wr_req.aw_addr; obs_strb = wr_req.w_strb; end
            if (rd_req.ar_valid) begin obs_ar = 1'b1; obs_addr = rd_req.ar_addr; end
            wr_rsp.b_valid = wr_req.b_ready;
            rd_rsp.r_valid = rd_req.r_ready;
            if (tl_d2h.d_valid) begin
                obs_got = 1'b1; obs_lat = i;
                obs_op = tl_d2h.d_opcode; obs_err = tl_d2h.d_error; obs_data = tl_d2h.d_data;
                obs_src = tl_d2h.d_source; obs_size = tl_d2h.d_size;
            end else begin
                @(negedge clk);
            end
        end
        wr_rsp = '0;
        rd_rsp = '0;
        if (ack_d && obs_got) begin
            tl_h2d.d_ready = 1'b1;
            @(negedge clk);
            tl_h2d.d_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        tl_h2d = '0; wr_rsp = '0; rd_rsp = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (wr_req.aw_valid !== 1'b0 || wr_req.w_valid !== 1'b0 || wr_req.b_ready !== 1'b0) begin n_miss++; $display("FAIL reset_wr_handshakes: got aw=%b w=%b b=%b want 0", wr_req.aw_valid, wr_req.w_valid, wr_req.b_ready); end
        n_vec++; if (rd_req.ar_valid !== 1'b0 || rd_req.r_ready !== 1'b0) begin n_miss++; $display("FAIL reset_rd_handshakes: got ar=%b r=%b want 0", rd_req.ar_valid, rd_req.r_ready); end
        n_vec++; if (tl_d2h !== '0) begin n_miss++; $display("FAIL reset_d_channel: got %h want 0", tl_d2h); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (tl_d2h.a_ready !== 1'b1) begin n_miss++; $display("FAIL reset_a_ready: got %b want 1", tl_d2h.a_ready); end
    endtask

    task automatic test_put();
        bit ok;
        drive_a(OP_PUT_FULL, 32'h100, 2'd2, 4'hF, 32'hDEADBEEF, 8'h11, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL put_accept: got %b want 1", ok); end
        // cycle 1: AW and W raised together, awready held low
        n_vec++; if (wr_req.aw_valid !== 1'b1 || wr_req.w_valid !== 1'b1) begin n_miss++; $display("FAIL put_valids: got aw=%b w=%b want 1 1", wr_req.aw_valid, wr_req.w_valid); end
        n_vec++; if (wr_req.aw_addr !== 32'h100) begin n_miss++; $display("FAIL put_awaddr: got %h want 00000100", wr_req.aw_addr); end
        n_vec++; if (wr_req.w_strb !== 4'hF || wr_req.w_last !== 1'b1) begin n_miss++; $display("FAIL put_wstrb_wlast: got %h/%b want f/1", wr_req.w_strb, wr_req.w_last); end
        n_vec++; if (wr_req.w_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL put_wdata: got %h want deadbeef", wr_req.w_data); end
        n_vec++; if (wr_req.aw_size !== 3'd2 || wr_req.aw_len !== 8'd0 || wr_req.aw_burst !== 2'b01 || wr_req.aw_id !== 4'd0) begin n_miss++; $display("FAIL put_aw_fixed: got size=%0d len=%0d burst=%b id=%0d want 2 0 01 0", wr_req.aw_size, wr_req.aw_len, wr_req.aw_burst, wr_req.aw_id); end
        n_vec++; if (tl_d2h.a_ready !== 1'b0) begin n_miss++; $display("FAIL put_a_ready_busy: got %b want 0", tl_d2h.a_ready); end
        wr_rsp.aw_ready = 1'b0; wr_rsp.w_ready = 1'b1;
        @(negedge clk);
        wr_rsp.w_ready = 1'b0;
        n_vec++; if (wr_req.w_valid !== 1'b0 || wr_req.aw_valid !== 1'b1) begin n_miss++; $display("FAIL put_w_done_aw_held: got aw=%b w=%b want 1 0", wr_req.aw_valid, wr_req.w_valid); end
        @(negedge clk);
        n_vec++; if (wr_req.aw_valid !== 1'b1 || wr_req.w_valid !== 1'b0 || wr_req.aw_addr !== 32'h100) begin n_miss++; $display("FAIL put_aw_hold: got aw=%b w=%b addr=%h want 1 0 100", wr_req.aw_valid, wr_req.w_valid, wr_req.aw_addr); end
        wr_rsp.aw_ready = 1'b1;
        @(negedge clk);
        wr_rsp.aw_ready = 1'b0;
        n_vec++; if (wr_req.aw_valid !== 1'b0 || wr_req.b_ready !== 1'b1) begin n_miss++; $display("FAIL put_to_wr_b: got aw=%b bready=%b want 0 1", wr_req.aw_valid, wr_req.b_ready); end
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (obs_got !== 1'b1) begin n_miss++; $display("FAIL put_d_seen: got %b want 1", obs_got); end
        n_vec++; if (obs_op !== OP_ACCESS_ACK || obs_err !== 1'b0) begin n_miss++; $display("FAIL put_d_fields: got op=%0d err=%b want 0 0", obs_op, obs_err); end
        n_vec++; if (obs_src !== 8'h11 || obs_size !== 2'd2) begin n_miss++; $display("FAIL put_d_echo: got src=%h size=%0d want 11 2", obs_src, obs_size); end
        n_vec++; if (tl_d2h.d_valid !== 1'b0 || tl_d2h.a_ready !== 1'b1) begin n_miss++; $display("FAIL put_back_idle: got dvalid=%b aready=%b want 0 1", tl_d2h.d_valid, tl_d2h.a_ready); end
    endtask

    task automatic test_get();
        bit ok;
        drive_a(OP_GET, 32'h204, 2'd2, 4'hF, 32'h0, 8'h22, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL get_accept: got %b want 1", ok); end
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h12345678);
        n_vec++; if (obs_ar !== 1'b1 || obs_aw !== 1'b0 || obs_addr !== 32'h204) begin n_miss++; $display("FAIL get_ar: got ar=%b aw=%b addr=%h want 1 0 204", obs_ar, obs_aw, obs_addr); end
        n_vec++; if (obs_got !== 1'b1 || obs_lat !== 3) begin n_miss++; $display("FAIL get_latency: got seen=%b cycle=%0d want 1 3", obs_got, obs_lat); end
        n_vec++; if (obs_op !== OP_ACCESS_ACK_DATA || obs_err !== 1'b0) begin n_miss++; $display("FAIL get_d_fields: got op=%0d err=%b want 1 0", obs_op, obs_err); end
        n_vec++; if (obs_data !== 32'h12345678) begin n_miss++; $display("FAIL get_d_data: got %h want 12345678", obs_data); end
        n_vec++; if (obs_src !== 8'h22) begin n_miss++; $display("FAIL get_d_source: got %h want 22", obs_src); end
    endtask

    task automatic test_error_rsp();
        bit ok;
        drive_a(OP_GET, 32'h208, 2'd2, 4'hF, 32'h0, 8'h05, ok);
        respond(1'b1, 4'd0, 2'b10, 1'b1, 32'h55AA55AA);
        n_vec++; if (ok !== 1'b1 || obs_got !== 1'b1 || obs_err !== 1'b1 || obs_data !== 32'h0) begin n_miss++; $display("FAIL err_rresp_slverr: got ok=%b seen=%b err=%b data=%h want 1 1 1 0", ok, obs_got, obs_err, obs_data); end
        drive_a(OP_PUT_PARTIAL, 32'h9, 2'd0, 4'h2, 32'h0000AB00, 8'h06, ok);
        respond(1'b1, 4'd3, 2'b00, 1'b1, 32'h0);
        n_vec++; if (ok !== 1'b1 || obs_aw !== 1'b1 || obs_strb !== 4'h2 || obs_err !== 1'b1 || obs_op !== OP_ACCESS_ACK) begin n_miss++; $display("FAIL err_bid: got ok=%b aw=%b strb=%h err=%b op=%0d want 1 1 2 1 0", ok, obs_aw, obs_strb, obs_err, obs_op); end
        drive_a(OP_GET, 32'h20C, 2'd2, 4'hF, 32'h0, 8'h07, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b0, 32'h11112222);
        n_vec++; if (ok !== 1'b1 || obs_err !== 1'b1 || obs_data !== 32'h0) begin n_miss++; $display("FAIL err_rlast: got ok=%b err=%b data=%h want 1 1 0", ok, obs_err, obs_data); end
    endtask

    task automatic test_bad_req();
        bit ok;
        drive_a(OP_GET, 32'h102, 2'd2, 4'hF, 32'h0, 8'h08, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'hFFFFFFFF);
        n_vec++; if (ok !== 1'b1 || obs_err !== 1'b1 || obs_ar !== 1'b0 || obs_op !== OP_ACCESS_ACK_DATA || obs_data !== 32'h0) begin n_miss++; $display("FAIL bad_get_misaligned: got ok=%b err=%b ar=%b op=%0d data=%h want 1 1 0 1 0", ok, obs_err, obs_ar, obs_op, obs_data); end
        n_vec++; if (obs_lat !== 1) begin n_miss++; $display("FAIL bad_get_latency: got %0d want 1", obs_lat); end
        drive_a(OP_PUT_FULL, 32'h2, 2'd1, 4'h3, 32'h0, 8'h09, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (ok !== 1'b1 || obs_err !== 1'b1 || obs_aw !== 1'b0 || obs_op !== OP_ACCESS_ACK) begin n_miss++; $display("FAIL bad_putfull_mask: got ok=%b err=%b aw=%b op=%0d want 1 1 0 0", ok, obs_err, obs_aw, obs_op); end
        drive_a(3'h2, 32'h0, 2'd2, 4'hF, 32'h0, 8'h0A, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (obs_err !== 1'b1 || obs_aw !== 1'b0 || obs_ar !== 1'b0) begin n_miss++; $display("FAIL bad_opcode: got err=%b aw=%b ar=%b want 1 0 0", obs_err, obs_aw, obs_ar); end
        // partial write with a subset of the covered lanes is legal
        drive_a(OP_PUT_PARTIAL, 32'h2, 2'd1, 4'h4, 32'h00330000, 8'h0B, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (obs_err !== 1'b0 || obs_aw !== 1'b1 || obs_addr !== 32'h2 || obs_strb !== 4'h4) begin n_miss++; $display("FAIL good_putpartial: got err=%b aw=%b addr=%h strb=%h want 0 1 2 4", obs_err, obs_aw, obs_addr, obs_strb); end
        drive_a(OP_GET, 32'h1, 2'd0, 4'h4, 32'h0, 8'h0C, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (obs_err !== 1'b1 || obs_ar !== 1'b0) begin n_miss++; $display("FAIL bad_mask_outside: got err=%b ar=%b want 1 0", obs_err, obs_ar); end
    endtask

    task automatic test_backpressure();
        bit ok;
        drive_a(OP_GET, 32'h300, 2'd2, 4'hF, 32'h0, 8'h33, ok);
        respond(1'b0, 4'd0, 2'b00, 1'b1, 32'hCAFEF00D);
        n_vec++; if (ok !== 1'b1 || obs_got !== 1'b1) begin n_miss++; $display("FAIL bp_first: got ok=%b seen=%b want 1 1", ok, obs_got); end
        tl_h2d.a_opcode = OP_PUT_FULL; tl_h2d.a_address = 32'h10; tl_h2d.a_size = 2'd2;
        tl_h2d.a_mask = 4'hF; tl_h2d.a_data = 32'hA5A5A5A5; tl_h2d.a_source = 8'h44;
        tl_h2d.a_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (tl_d2h.d_valid !== 1'b1 || tl_d2h.d_data !== 32'hCAFEF00D || tl_d2h.d_source !== 8'h33 || tl_d2h.d_opcode !== OP_ACCESS_ACK_DATA || tl_d2h.d_error !== 1'b0 || tl_d2h.a_ready !== 1'b0) begin n_miss++; $display("FAIL bp_hold_%0d: got v=%b data=%h src=%h op=%0d err=%b ardy=%b want 1 cafef00d 33 1 0 0", k, tl_d2h.d_valid, tl_d2h.d_data, tl_d2h.d_source, tl_d2h.d_opcode, tl_d2h.d_error, tl_d2h.a_ready); end
            @(negedge clk);
        end
        tl_h2d.d_ready = 1'b1;
        @(negedge clk);
        tl_h2d.d_ready = 1'b0;
        n_vec++; if (tl_d2h.d_valid !== 1'b0 || tl_d2h.a_ready !== 1'b1 || wr_req.aw_valid !== 1'b0) begin n_miss++; $display("FAIL bp_after_ack: got v=%b ardy=%b aw=%b want 0 1 0", tl_d2h.d_valid, tl_d2h.a_ready, wr_req.aw_valid); end
        @(negedge clk);
        tl_h2d.a_valid = 1'b0;
        n_vec++; if (tl_d2h.a_ready !== 1'b0 || wr_req.aw_valid !== 1'b1 || wr_req.w_data !== 32'hA5A5A5A5) begin n_miss++; $display("FAIL bp_second_accept: got ardy=%b aw=%b wdata=%h want 0 1 a5a5a5a5", tl_d2h.a_ready, wr_req.aw_valid, wr_req.w_data); end
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0);
        n_vec++; if (obs_got !== 1'b1 || obs_err !== 1'b0 || obs_src !== 8'h44 || obs_addr !== 32'h10) begin n_miss++; $display("FAIL bp_second_done: got seen=%b err=%b src=%h addr=%h want 1 0 44 10", obs_got, obs_err, obs_src, obs_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive_a(OP_PUT_FULL, 32'h40, 2'd2, 4'hF, 32'h01020304, 8'h55, ok);
        wr_rsp.aw_ready = 1'b1; wr_rsp.w_ready = 1'b1;
        @(negedge clk);
        wr_rsp = '0;
        n_vec++; if (ok !== 1'b1 || wr_req.b_ready !== 1'b1) begin n_miss++; $display("FAIL rst_mid_in_wr_b: got ok=%b bready=%b want 1 1", ok, wr_req.b_ready); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (wr_req.aw_valid !== 1'b0 || wr_req.w_valid !== 1'b0 || wr_req.b_ready !== 1'b0 || rd_req.ar_valid !== 1'b0 || rd_req.r_ready !== 1'b0 || tl_d2h.d_valid !== 1'b0 || tl_d2h.a_ready !== 1'b0) begin n_miss++; $display("FAIL rst_mid_cleared: got aw=%b w=%b b=%b ar=%b r=%b dv=%b ardy=%b want all 0", wr_req.aw_valid, wr_req.w_valid, wr_req.b_ready, rd_req.ar_valid, rd_req.r_ready, tl_d2h.d_valid, tl_d2h.a_ready); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (tl_d2h.d_valid !== 1'b0) begin n_miss++; $display("FAIL rst_mid_no_d_%0d: got %b want 0", k, tl_d2h.d_valid); end
        end
        drive_a(OP_GET, 32'h80, 2'd2, 4'hF, 32'h0, 8'h66, ok);
        respond(1'b1, 4'd0, 2'b00, 1'b1, 32'h0BADF00D);
        n_vec++; if (ok !== 1'b1 || obs_got !== 1'b1 || obs_err !== 1'b0 || obs_data !== 32'h0BADF00D || obs_src !== 8'h66) begin n_miss++; $display("FAIL rst_mid_get_after: got ok=%b seen=%b err=%b data=%h src=%h want 1 1 0 0badf00d 66", ok, obs_got, obs_err, obs_data, obs_src); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_put();
        test_get();
        test_error_rsp();
        test_bad_req();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
